// File: rtl/crc_check.sv
// Receive-side USB CRC checker: skips SYNC+PID, runs CRC5/CRC16 over the body
// (payload plus received CRC), then checks the residual and the body length.
module crc_check #(
  parameter int MAX_DATA_BYTES = 1024,
  parameter int CNT_W          = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_in,
  input  logic       start,
  input  logic       endr,
  input  logic       pause,
  input  logic [1:0] pkt_type,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

  localparam logic [4:0]       POLY5    = 5'b00101;
  localparam logic [15:0]      POLY16   = 16'h8005;
  localparam logic [4:0]       RES5     = 5'b01100;
  localparam logic [15:0]      RES16    = 16'h800D;
  localparam logic [CNT_W-1:0] CRC_BITS = CNT_W'(16);
  localparam logic [CNT_W-1:0] MAX_BITS = CNT_W'(8 * MAX_DATA_BYTES + 16);

  state_t           state, state_nxt;
  logic [1:0]       typ;
  logic [4:0]       crc5;
  logic [15:0]      crc16;
  logic [3:0]       hdr_cnt;
  logic [CNT_W-1:0] body_cnt;
  logic             bit_vld;
  logic             pass;
  logic             x5, x16;

  assign bit_vld = ((state == HDR) || (state == BODY)) && !pause && !endr;
  assign busy    = (state == HDR) || (state == BODY);
  assign done    = (state == DONE);
  assign x5      = crc5[4] ^ s_in;
  assign x16     = crc16[15] ^ s_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // start overrides everything, including endr and the DONE cycle
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = HDR;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        HDR: begin
          if (endr)                           state_nxt = DONE;
          else if (bit_vld && hdr_cnt == 4'hF) state_nxt = BODY;
        end
        BODY:    if (endr) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Verdict evaluated on the endr cycle; endr while still in HDR never passes.
  always_comb begin
    pass = 1'b0;
    case (typ)
      2'b00: pass = (body_cnt == '0);
      2'b01: pass = (body_cnt == CRC_BITS) && (crc5 == RES5);
      2'b10: pass = (body_cnt >= CRC_BITS) && (body_cnt[2:0] == 3'b000) &&
                    (body_cnt <= MAX_BITS) && (crc16 == RES16);
      default: pass = 1'b0;
    endcase
    if (state != BODY) pass = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typ      <= 2'b00;
      crc5     <= 5'h1F;
      crc16    <= 16'hFFFF;
      hdr_cnt  <= '0;
      body_cnt <= '0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else if (start) begin
      typ      <= pkt_type;
      crc5     <= 5'h1F;
      crc16    <= 16'hFFFF;
      hdr_cnt  <= '0;
      body_cnt <= '0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      if (bit_vld && state == HDR) hdr_cnt <= hdr_cnt + 4'd1;
      if (bit_vld && state == BODY) begin
        crc5  <= {crc5[3:0], 1'b0} ^ (x5 ? POLY5 : 5'b0);
        crc16 <= {crc16[14:0], 1'b0} ^ (x16 ? POLY16 : 16'b0);
        if (body_cnt != '1) body_cnt <= body_cnt + 1'b1;
      end
      if (endr && (state == HDR || state == BODY)) begin
        crc_ok  <= pass;
        crc_err <= !pass;
      end
    end
  end

endmodule
